// File: rtl/toggle_cover_collector_if.sv
// ---------------------------------------------------------------------------
// toggle_cover_collector_if
//   Report stream from the toggle-cover collector to its consumer (coverage
//   uploader or FIFO). A report transfers on a clock edge where out_valid
//   and out_ready are both high.
//
//   out_valid  collector -> consumer  report available
//   out_ready  consumer  -> collector consumer accepts the report
//   out_index  collector -> consumer  absolute cover index (IDX_W bits)
//
//   master modport: the collector side. slave modport: the consumer side.
// ---------------------------------------------------------------------------
interface toggle_cover_collector_if #(
   parameter int IDX_W = 64
);
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_index;

   modport master (
      output out_valid,
      output out_index,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_index,
      output out_ready
   );
endinterface

// File: rtl/toggle_cover_collector.sv
// ---------------------------------------------------------------------------
// toggle_cover_collector
//   Captures a per-bit toggle-cover pulse vector into a sticky hit bitmap and
//   reports every newly hit point exactly once, as an absolute cover index,
//   on a valid/ready stream. Simultaneous hits drain lowest index first, one
//   report per cycle under continuous acceptance. Pulse-to-report latency is
//   two cycles.
//
//   clock      clock
//   reset      synchronous, active-low reset
//   valid      WIDTH-bit cover pulses; bit i high = point i hit this cycle
//   clear      starts a new coverage epoch (empties hit and pending sets)
//   stream     report stream (master side: out_valid, out_ready, out_index)
//   hit_count  number of points hit in the current epoch
//   all_hit    every point hit in the current epoch
// ---------------------------------------------------------------------------
module toggle_cover_collector #(
   parameter int              WIDTH       = 62,
   parameter longint unsigned COVER_INDEX = 0,
   parameter int              IDX_W       = 64
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [WIDTH-1:0]             valid,
   input  logic                         clear,
   toggle_cover_collector_if.master     stream,
   output logic [$clog2(WIDTH+1)-1:0]   hit_count,
   output logic                         all_hit
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   hit_q, hit_d;
   logic [WIDTH-1:0]   pend_q, pend_d;
   logic [IDX_W-1:0]   idx_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               all_q;

   logic [WIDTH-1:0]   base;
   logic [WIDTH-1:0]   new_bits;
   logic [WIDTH-1:0]   load_mask;
   logic [POS_W-1:0]   low_pos;
   logic               pend_any;
   logic               load;

   // Bitmap and pending-set next state. clear zeroes the old epoch, but pulses
   // in the same cycle still land in the new one.
   always_comb begin
      base     = clear ? '0 : hit_q;
      new_bits = valid & ~base;
      hit_d    = base | valid;
      pend_d   = (clear ? '0 : (pend_q & ~load_mask)) | new_bits;
   end

   // Lowest set bit of the registered pending set; the downward scan leaves
   // the smallest index as the final assignment.
   always_comb begin
      low_pos = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (pend_q[i]) low_pos = POS_W'(i);
      end
   end

   assign pend_any = |pend_q;

   // Output FSM. A load is suppressed while clear is high: the pending set
   // seen this cycle belongs to the epoch being discarded.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      state_d   = state_q;
      load      = 1'b0;
      load_mask = '0;
      case (state_q)
         EMPTY: begin
            if (pend_any && !clear) begin
               load    = 1'b1;
               state_d = FULL;
            end
         end
         FULL: begin
            if (stream.out_ready) begin
               if (pend_any && !clear) load    = 1'b1;
               else                    state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (load) load_mask[low_pos] = 1'b1;
   end

   // Population count of the next-state bitmap, so hit_count moves in the
   // same cycle as hit_q.
   always_comb begin
      cnt_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d = cnt_d + CNT_W'(hit_d[i]);
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (!reset) begin
         // NOTE: the bitmap is a flop array, not a RAM, so clearing it on
         // reset is cheap and makes the first epoch start from a known state.
         state_q <= EMPTY;
         hit_q   <= '0;
         pend_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         all_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hit_q   <= hit_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         all_q   <= (cnt_d == CNT_W'(WIDTH));
         if (load) idx_q <= IDX_W'(COVER_INDEX) + IDX_W'(low_pos);
      end
   end

   assign stream.out_valid = (state_q == FULL);
   assign stream.out_index = idx_q;
   assign hit_count        = cnt_q;
   assign all_hit          = all_q;

endmodule

// File: tb/tb_toggle_cover_collector.sv
// ---------------------------------------------------------------------------
// tb_toggle_cover_collector
//   Directed bench for toggle_cover_collector (WIDTH=62, COVER_INDEX=100).
//   A table of per-cycle {inputs, expected outputs} rows covers reset, single
//   hit, repeat hit, burst ordering, backpressure, clear mid-stream and
//   mid-transfer reset. A hand-written sequence then pulses every point once
//   in shuffled order and scoreboards the reports.
// ---------------------------------------------------------------------------
module tb_toggle_cover_collector;

   localparam int          WIDTH = 62;
   localparam int          CIDX  = 100;
   localparam int          IDX_W = 64;
   localparam int          CNT_W = $clog2(WIDTH + 1);

   localparam logic [WIDTH-1:0] V_NONE  = '0;
   localparam logic [WIDTH-1:0] V_ALL   = '1;
   localparam logic [WIDTH-1:0] V3      = WIDTH'(1) << 3;
   localparam logic [WIDTH-1:0] V5      = WIDTH'(1) << 5;
   localparam logic [WIDTH-1:0] V7      = WIDTH'(1) << 7;
   localparam logic [WIDTH-1:0] V_BURST = (WIDTH'(1) << 0) | (WIDTH'(1) << 3) | (WIDTH'(1) << 61);

   typedef struct {
      logic             rst;
      logic [WIDTH-1:0] vld;
      logic             clr;
      logic             rdy;
      logic             e_ov;
      logic             chk_idx;
      int               e_idx;
      int               e_cnt;
      logic             e_all;
   } vec_t;

   logic             clock = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] valid;
   logic             clear;
   logic [CNT_W-1:0] hit_count;
   logic             all_hit;

   toggle_cover_collector_if #(.IDX_W(IDX_W)) stream_if ();

   toggle_cover_collector #(
      .WIDTH       (WIDTH),
      .COVER_INDEX (CIDX),
      .IDX_W       (IDX_W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .valid     (valid),
      .clear     (clear),
      .stream    (stream_if),
      .hit_count (hit_count),
      .all_hit   (all_hit)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rst, input logic [WIDTH-1:0] vld,
                               input logic clr, input logic rdy,
                               input logic e_ov, input logic chk_idx,
                               input int e_idx, input int e_cnt, input logic e_all);
      vec_t v;
      v.rst = rst; v.vld = vld; v.clr = clr; v.rdy = rdy;
      v.e_ov = e_ov; v.chk_idx = chk_idx; v.e_idx = e_idx;
      v.e_cnt = e_cnt; v.e_all = e_all;
      return v;
   endfunction

   vec_t vecs[$];
   int   perm[WIDTH];
   bit   seen[WIDTH];
   int   n_reports;

   // Records a report sampled after the edge into the coverage scoreboard.
   task automatic sample_report();
      longint k;
      if (stream_if.out_valid) begin
         k = longint'(stream_if.out_index) - CIDX;
         n_reports++;
         check("cov_index_range", (k >= 0 && k < WIDTH) ? 1 : 0, 1);
         if (k >= 0 && k < WIDTH) begin
            check($sformatf("cov_dup_%0d", k), seen[k], 0);
            seen[k] = 1'b1;
         end
      end
   endtask

   initial begin
      reset = 1'b0; valid = V_ALL; clear = 1'b0; stream_if.out_ready = 1'b1;

      // rst, valid, clr, rdy  ->  out_valid, check idx, idx, hit_count, all_hit
      // Reset with every pulse asserted: nothing is recorded.
      repeat (3) vecs.push_back(mk(0, V_ALL,  0, 1,  0, 1,   0, 0, 0));
      repeat (3) vecs.push_back(mk(1, V_NONE, 0, 1,  0, 1,   0, 0, 0));
      // Single hit on bit 5: count after one cycle, report after two, one cycle.
      vecs.push_back(mk(1, V5,     0, 1,  0, 0,   0, 1, 0));
      vecs.push_back(mk(1, V_NONE, 0, 1,  1, 1, 105, 1, 0));
      vecs.push_back(mk(1, V_NONE, 0, 1,  0, 0,   0, 1, 0));
      // Repeat pulse on bit 5 is ignored.
      vecs.push_back(mk(1, V5,     0, 1,  0, 0,   0, 1, 0));
      vecs.push_back(mk(1, V_NONE, 0, 1,  0, 0,   0, 1, 0));
      vecs.push_back(mk(1, V_NONE, 0, 1,  0, 0,   0, 1, 0));
      // New epoch with burst {0,3,61}: ascending order, back-to-back.
      vecs.push_back(mk(1, V_BURST, 1, 1, 0, 0,   0, 3, 0));
      vecs.push_back(mk(1, V_NONE, 0, 1,  1, 1, 100, 3, 0));
      vecs.push_back(mk(1, V_NONE, 0, 1,  1, 1, 103, 3, 0));
      vecs.push_back(mk(1, V_NONE, 0, 1,  1, 1, 161, 3, 0));
      vecs.push_back(mk(1, V_NONE, 0, 1,  0, 0,   0, 3, 0));
      // Same burst under ten cycles of backpressure.
      vecs.push_back(mk(1, V_BURST, 1, 0, 0, 0,   0, 3, 0));
      repeat (10) vecs.push_back(mk(1, V_NONE, 0, 0, 1, 1, 100, 3, 0));
      vecs.push_back(mk(1, V_NONE, 0, 1,  1, 1, 103, 3, 0));
      vecs.push_back(mk(1, V_NONE, 0, 1,  1, 1, 161, 3, 0));
      vecs.push_back(mk(1, V_NONE, 0, 1,  0, 0,   0, 3, 0));
      // Clear mid-stream with valid[3]: 100 held, then 103, 161 never.
      vecs.push_back(mk(1, V_BURST, 1, 0, 0, 0,   0, 3, 0));
      vecs.push_back(mk(1, V_NONE, 0, 0,  1, 1, 100, 3, 0));
      vecs.push_back(mk(1, V3,     1, 0,  1, 1, 100, 1, 0));
      vecs.push_back(mk(1, V_NONE, 0, 0,  1, 1, 100, 1, 0));
      vecs.push_back(mk(1, V_NONE, 0, 1,  1, 1, 103, 1, 0));
      vecs.push_back(mk(1, V_NONE, 0, 1,  0, 0,   0, 1, 0));
      vecs.push_back(mk(1, V_NONE, 0, 1,  0, 0,   0, 1, 0));
      // Reset during a held report drops it.
      vecs.push_back(mk(1, V7,     0, 0,  0, 0,   0, 2, 0));
      vecs.push_back(mk(1, V_NONE, 0, 0,  1, 1, 107, 2, 0));
      vecs.push_back(mk(0, V_NONE, 0, 0,  0, 1,   0, 0, 0));
      vecs.push_back(mk(1, V_NONE, 0, 1,  0, 0,   0, 0, 0));
      vecs.push_back(mk(1, V_NONE, 0, 1,  0, 0,   0, 0, 0));

      foreach (vecs[r]) begin
         reset               = vecs[r].rst;
         valid               = vecs[r].vld;
         clear               = vecs[r].clr;
         stream_if.out_ready = vecs[r].rdy;
         @(posedge clock); #1;
         check($sformatf("row%0d_out_valid", r), stream_if.out_valid, vecs[r].e_ov);
         check($sformatf("row%0d_hit_count", r), hit_count, vecs[r].e_cnt);
         check($sformatf("row%0d_all_hit", r), all_hit, vecs[r].e_all);
         if (vecs[r].chk_idx)
            check($sformatf("row%0d_out_index", r), longint'(stream_if.out_index), vecs[r].e_idx);
      end

      // Full coverage: every point pulsed once in shuffled order.
      for (int i = 0; i < WIDTH; i++) begin
         perm[i] = i;
         seen[i] = 1'b0;
      end
      for (int i = WIDTH - 1; i > 0; i--) begin
         int j, t;
         j = $urandom_range(i, 0);
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      n_reports = 0;

      reset = 1'b1; valid = V_NONE; clear = 1'b1; stream_if.out_ready = 1'b1;
      @(posedge clock); #1;
      sample_report();
      clear = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         valid = WIDTH'(1) << perm[i];
         @(posedge clock); #1;
         sample_report();
         check($sformatf("cov_hit_count_%0d", i), hit_count, i + 1);
         if (i == WIDTH - 2) check("cov_all_hit_early", all_hit, 0);
      end
      check("cov_all_hit", all_hit, 1);
      valid = V_NONE;
      repeat (8) begin
         @(posedge clock); #1;
         sample_report();
      end
      check("cov_report_total", n_reports, WIDTH);
      check("cov_drained", stream_if.out_valid, 0);
      check("cov_final_count", hit_count, WIDTH);
      check("cov_final_all_hit", all_hit, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
